// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: programmable burst of N rectangular pulses with busy/done status.
// Optional abort input/aborted strobe enabled by defining PULSE_BURST_ABORT_EN.
module pulse_burst_gen #(
    parameter int CNT_W = 4,
    parameter int WID_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [WID_W-1:0] high_cycles,
    input  logic [WID_W-1:0] low_cycles,
`ifdef PULSE_BURST_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;

    localparam logic [WID_W-1:0] W1 = 1;
    localparam logic [CNT_W-1:0] C1 = 1;

    state_t           state_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] sent_q;
    logic [WID_W-1:0] hi_q;
    logic [WID_W-1:0] lo_q;
    logic [WID_W-1:0] ph_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;
    logic [WID_W-1:0] h_eff;
    logic [WID_W-1:0] l_eff;
`ifdef PULSE_BURST_ABORT_EN
    logic             aborted_q;
    assign aborted = aborted_q;
`endif

    // A programmed width of zero still yields a one-cycle phase.
    assign h_eff = (high_cycles == '0) ? W1 : high_cycles;
    assign l_eff = (low_cycles == '0) ? W1 : low_cycles;

    assign pulse_out   = pulse_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulses_sent = sent_q;

    // Burst sequencer: phase counter counts elapsed cycles of the current HIGH/LOW phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            sent_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            ph_q      <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PULSE_BURST_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
`ifdef PULSE_BURST_ABORT_EN
            aborted_q <= 1'b0;
            if (abort && (state_q == HIGH || state_q == LOW)) begin
                state_q   <= IDLE;
                pulse_q   <= 1'b0;
                busy_q    <= 1'b0;
                ph_q      <= '0;
                aborted_q <= 1'b1;
            end else
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q  <= burst_len;
                        hi_q   <= h_eff;
                        lo_q   <= l_eff;
                        sent_q <= '0;
                        ph_q   <= '0;
                        if (burst_len == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= HIGH;
                            pulse_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (ph_q == hi_q - W1) begin
                        state_q <= LOW;
                        pulse_q <= 1'b0;
                        ph_q    <= '0;
                        sent_q  <= sent_q + C1;
                    end else begin
                        ph_q <= ph_q + W1;
                    end
                end
                LOW: begin
                    if (ph_q == lo_q - W1) begin
                        ph_q <= '0;
                        if (sent_q == len_q) begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= HIGH;
                            pulse_q <= 1'b1;
                        end
                    end else begin
                        ph_q <= ph_q + W1;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pulse_burst_gen.md
Name: pulse_burst_gen

Overview:
- Transmit-side counterpart to the edge-triggered pulse counter.
- Emits a programmable burst of N rectangular pulses on a single output line, with programmable high and low widths measured in clock cycles.
- Used as an on-chip stimulus source that can be looped back into the counter's ext_in, or driven off-chip on a uo_out bit.
- Provides busy/done status and a count of completed pulses.

Parameters:
- CNT_W, default 4, width of burst length and of the sent-pulse counter. Maximum burst is 2^CNT_W-1 pulses.
- WID_W, default 8, width of the high-phase and low-phase duration fields, in clock cycles.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- burst_len  input  CNT_W  number of pulses to emit; latched on an accepted start.
- high_cycles  input  WID_W  high-phase width in cycles; latched on an accepted start.
- low_cycles  input  WID_W  low-phase width in cycles; latched on an accepted start.
- pulse_out  output  1  generated pulse line; registered, glitch-free.
- busy  output  1  high from the cycle after an accepted start until done is asserted.
- done  output  1  one-cycle strobe when the burst completes.
- pulses_sent  output  CNT_W  number of pulses completed in the current or last burst.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values (applied immediately on rst, independent of clk):
  - state=IDLE; pulse_out=0; busy=0; done=0; pulses_sent=0.
  - Latched length and width registers = 0; phase counter = 0.
- Width rule: a latched width of 0 is treated as 1. Effective high width H=max(high_cycles,1); effective low width L=max(low_cycles,1).
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states: IDLE, HIGH, LOW, FIN.
- IDLE:
  - start=1 is accepted. Latch burst_len, H and L; clear pulses_sent to 0.
  - If burst_len==0: go to FIN.
  - Otherwise: go to HIGH.
  - start=0: remain in IDLE.
- HIGH:
  - pulse_out=1 and busy=1.
  - Phase counter runs H cycles, then go to LOW.
  - pulses_sent increments by 1 on the HIGH->LOW transition.
- LOW:
  - pulse_out=0 and busy=1.
  - Phase counter runs L cycles.
  - If pulses_sent==latched burst_len: go to FIN. Otherwise go to HIGH.
- FIN:
  - done=1 and busy=0 for exactly one cycle, then go to IDLE.
- Latency and timing:
  - start accepted at clock edge k -> pulse_out rises at edge k+1.
  - A burst of N pulses occupies N*(H+L) cycles from edge k+1.
  - done is high during the cycle beginning at edge k+1+N*(H+L).
  - A zero-length burst gives done at edge k+1, with busy never asserted.
- Simultaneous events and boundaries:
  - start while busy, or in FIN, is ignored. Latched values are unchanged.
  - start in the IDLE cycle immediately following FIN is accepted (back-to-back bursts).
  - Input changes during a burst have no effect; only the values latched at start are used.
  - burst_len=2^CNT_W-1 must complete without pulses_sent wrapping.
  - pulses_sent holds its final value after done until the next accepted start.
  - The low phase of the last pulse is always emitted before done.
  - rst asserted mid-burst forces pulse_out=0 immediately (asynchronously) with no done strobe. After rst is released, the next start begins a fresh burst.

Optional Feature:
- Macro: PULSE_BURST_ABORT_EN.
- When defined:
  - Adds input abort (1 bit) and output aborted (1 bit, one-cycle strobe, reset 0).
  - abort=1 in HIGH or LOW -> next edge: pulse_out=0, busy=0, aborted=1 for one cycle, state=IDLE. done is not asserted.
  - pulses_sent keeps the count of pulses fully completed before the abort. A HIGH phase cut short is not counted.
  - abort takes priority over a same-cycle phase transition.
  - abort in IDLE or FIN is ignored.
- When undefined: no abort or aborted ports; the behaviour is exactly as above.

Test Plan:
- Reset: assert rst mid-HIGH with burst_len=5, high=3 -> pulse_out=0 without a clock edge; all outputs 0; no done.
- Basic burst: burst_len=3, high=2, low=3, start at edge k -> pulse_out high on edges k+1..k+2, k+6..k+7, k+11..k+12; done at edge k+16; pulses_sent=3.
- Zero cases: burst_len=0 -> done at k+1, busy stays 0. high=0, low=0, burst_len=2 -> pattern 1,0,1,0, then done at k+5.
- Ignore and back-to-back: pulse start during a burst -> no effect on timing. Start on the cycle after done with burst_len=1, high=1, low=1 -> pulse_out rises on the next edge.
- Max and loopback: burst_len=15, high=1, low=1, pulse_out looped to the edge-triggered counter -> counter advances by 15 from its pre-burst value (wrapping modulo 16); pulses_sent=15; no wrap of pulses_sent.
- Abort (PULSE_BURST_ABORT_EN): burst_len=4, high=2, low=2, abort during the 3rd HIGH -> pulse_out=0 next edge, aborted=1 for one cycle, pulses_sent=2, done never asserted.
